// File: rtl/sram_multiport_arbiter.sv
// Round-robin (optionally host-first) arbiter and sequencer for one
// single-port SRAM macro shared by NUM_CH req/ack channels.
module sram_multiport_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int AWIDTH        = 10,
  parameter int DWIDTH        = 32,
  parameter int RD_LATENCY    = 1,
  parameter int HOST_PRIORITY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*AWIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DWIDTH-1:0]   ch_wdata,
  input  logic [NUM_CH*DWIDTH/8-1:0] ch_be,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [DWIDTH-1:0]          ch_rdata,
  output logic                       busy,
  output logic                       sram_en,
  output logic [DWIDTH/8-1:0]        sram_we,
  output logic [AWIDTH-1:0]          sram_addr,
  output logic [DWIDTH-1:0]          sram_data_i,
  input  logic [DWIDTH-1:0]          sram_data_o
);

  localparam int BW = DWIDTH / 8;
  localparam int GW = $clog2(NUM_CH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [GW-1:0]     g_q, g_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]     be_q, be_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic [GW-1:0] gsel;
  logic          found;
  int            idx;
  int            gi;

  // Search starts just after the last grant, so the last winner goes last.
  always_comb begin
    gsel  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_req[idx[GW-1:0]]) begin
        found = 1'b1;
        gsel  = idx[GW-1:0];
      end
    end
    if (HOST_PRIORITY != 0 && ch_req[0]) gsel = '0;
  end

  assign gi = int'(gsel);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (|ch_req) begin
          g_d     = gsel;
          rr_d    = gsel;
          we_d    = ch_we[gsel];
          addr_d  = ch_addr[gi*AWIDTH +: AWIDTH];
          wdata_d = ch_wdata[gi*DWIDTH +: DWIDTH];
          be_d    = ch_be[gi*BW +: BW];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = 3'(RD_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = sram_data_o;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= GW'(NUM_CH - 1);
      g_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins are driven only in ACCESS, so they are 0 right after reset.
  always_comb begin
    sram_en     = (state_q == S_ACCESS);
    sram_addr   = sram_en ? addr_q : '0;
    sram_we     = (sram_en && we_q) ? be_q : '0;
    sram_data_i = (sram_en && we_q) ? wdata_q : '0;
    ch_ack      = '0;
    if (state_q == S_DONE) ch_ack[g_q] = 1'b1;
  end

  assign busy     = (state_q != S_IDLE);
  assign ch_rdata = rdata_q;

endmodule
